// File: rtl/ber_align_counter.sv
// ber_align_counter: per-channel BER checker that searches the reference delay,
// locks onto it and counts saturating errors/bits while locked.
module ber_align_counter #(
  parameter int N_CH       = 2,
  parameter int MAX_DELAY  = 512,
  parameter int WIN        = 64,
  parameter int LOCK_THR   = 2,
  parameter int UNLOCK_THR = 16,
  parameter int NB_CNT     = 64,
  localparam int NB_DLY    = $clog2(MAX_DELAY),
  localparam int NB_WIN    = $clog2(WIN + 1)
) (
  input  logic                     clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic [N_CH-1:0]          i_ref,
  input  logic [N_CH-1:0]          i_rx,
  input  logic                     i_clear,
  output logic [N_CH-1:0]          o_lock,
  output logic                     o_all_locked,
  output logic [N_CH*NB_DLY-1:0]   o_delay,
  output logic [N_CH*NB_CNT-1:0]   o_err,
  output logic [N_CH*NB_CNT-1:0]   o_bits
);
  typedef enum logic {SEARCH, LOCKED} state_t;
  logic              strobe, win_end;
  logic [NB_WIN-1:0] w;
  assign strobe  = i_enable & i_valid;
  assign win_end = strobe && (w == NB_WIN'(WIN - 1));
  always_ff @(posedge clock)
    if (!i_reset) w <= '0;
    else if (strobe) w <= win_end ? '0 : w + NB_WIN'(1);
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    state_t              st, st_nxt;
    logic [MAX_DELAY-1:0] taps;
    logic [MAX_DELAY-1:1] hist;
    logic [NB_DLY-1:0]   dly, dly_inc, dly_nxt;
    logic [NB_WIN-1:0]   ew, ew_fin;
    logic [NB_CNT-1:0]   err, bits;
    logic                mm, go_lock, go_unlock;
    // tap 0 is the live reference, older samples come from the history register
    assign taps = {hist, i_ref[k]};
    always_comb begin
      mm        = i_rx[k] ^ taps[dly];
      ew_fin    = (ew == NB_WIN'(WIN)) ? ew : ew + NB_WIN'(mm);
      dly_inc   = (dly == NB_DLY'(MAX_DELAY - 1)) ? '0 : dly + NB_DLY'(1);
      go_lock   = win_end && st == SEARCH && 32'(ew_fin) <= LOCK_THR;
      go_unlock = win_end && st == LOCKED && 32'(ew_fin) > UNLOCK_THR;
      st_nxt    = go_lock ? LOCKED : go_unlock ? SEARCH : st;
      dly_nxt   = ((win_end && st == SEARCH && !go_lock) || go_unlock) ? dly_inc : dly;
    end
    always_ff @(posedge clock)
      st <= !i_reset ? SEARCH : st_nxt;
    always_ff @(posedge clock)
      if (!i_reset) begin
        hist <= '0;
        dly  <= '0;
        ew   <= '0;
      end else if (strobe) begin
        hist <= taps[MAX_DELAY-2:0];
        dly  <= dly_nxt;
        ew   <= win_end ? '0 : ew_fin;
      end
    // a clear coinciding with a strobe wins, so that strobe is never counted
    always_ff @(posedge clock)
      if (!i_reset || i_clear) begin
        err  <= '0;
        bits <= '0;
      end else if (strobe && st == LOCKED) begin
        err  <= (&err) ? err : err + NB_CNT'(mm);
        bits <= (&bits) ? bits : bits + NB_CNT'(1);
      end
    assign o_lock[k]                     = st == LOCKED;
    assign o_delay[k*NB_DLY +: NB_DLY]   = dly;
    assign o_err[k*NB_CNT +: NB_CNT]     = err;
    assign o_bits[k*NB_CNT +: NB_CNT]    = bits;
  end
  assign o_all_locked = &o_lock;
endmodule

// File: tb/tb_ber_align_counter.sv
// tb_ber_align_counter: default-size instance for alignment/unlock/wrap scenarios,
// small instance for table vectors, saturation/enable and random model comparison.
module tb_ber_align_counter;
  localparam int AW = 64, ANB = 9, ACNT = 64;
  localparam int BD = 8, BW = 32, BNB = 3, BCNT = 4, BLT = 2, BUT = 4;
  localparam int BMAX = 2**BCNT - 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic a_reset, a_enable, a_valid, a_clear, a_all;
  logic [1:0] a_ref, a_rx, a_lock;
  logic [2*ANB-1:0] a_delay;
  logic [2*ACNT-1:0] a_err, a_bits;

  logic b_reset, b_enable, b_valid, b_clear, b_all;
  logic [1:0] b_ref, b_rx, b_lock;
  logic [2*BNB-1:0] b_delay;
  logic [2*BCNT-1:0] b_err, b_bits;

  ber_align_counter dut_a (
    .clock(clock), .i_reset(a_reset), .i_enable(a_enable), .i_valid(a_valid),
    .i_ref(a_ref), .i_rx(a_rx), .i_clear(a_clear), .o_lock(a_lock),
    .o_all_locked(a_all), .o_delay(a_delay), .o_err(a_err), .o_bits(a_bits));

  ber_align_counter #(.N_CH(2), .MAX_DELAY(BD), .WIN(BW), .LOCK_THR(BLT),
                      .UNLOCK_THR(BUT), .NB_CNT(BCNT)) dut_b (
    .clock(clock), .i_reset(b_reset), .i_enable(b_enable), .i_valid(b_valid),
    .i_ref(b_ref), .i_rx(b_rx), .i_clear(b_clear), .o_lock(b_lock),
    .o_all_locked(b_all), .o_delay(b_delay), .o_err(b_err), .o_bits(b_bits));

  int n_cmp = 0, n_bad = 0;
  logic [8:0] lfsr = 9'h1ff;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic prbs();
    logic b;
    b = lfsr[8] ^ lfsr[4];
    lfsr = {lfsr[7:0], b};
    return b;
  endfunction

  // default instance: both channels see i_ref delayed by 37 strobes
  bit ha[0:65535];
  int a_n = 0, since_clr = 0;
  task automatic a_strobe(input bit f0, input bit f1, input int idle);
    logic r, d;
    r = prbs();
    ha[a_n] = r;
    d = (a_n >= 37) ? ha[a_n-37] : 1'b0;
    a_ref = {r, r};
    a_rx = {d ^ f1, d ^ f0};
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    a_n++;
    since_clr = a_clear ? 0 : since_clr + 1;
    repeat (idle) step();
  endtask

  // reference model of the small instance: strobe history indexed by strobe number
  bit hb[2][0:4095];
  int m_n, m_w;
  int m_dly[2], m_lk[2], m_ew[2], m_err[2], m_bits[2];

  task automatic m_reset();
    m_n = 0;
    m_w = 0;
    for (int c = 0; c < 2; c++) begin
      m_dly[c] = 0; m_lk[c] = 0; m_ew[c] = 0; m_err[c] = 0; m_bits[c] = 0;
    end
  endtask

  task automatic b_cycle(input bit en, input bit v, input bit clr, input logic [1:0] r,
                         input logic [1:0] f, input int d0, input int d1);
    int dd[2];
    int mm;
    logic [1:0] x;
    dd[0] = d0;
    dd[1] = d1;
    for (int c = 0; c < 2; c++) begin
      hb[c][m_n] = r[c];
      x[c] = ((m_n >= dd[c]) ? hb[c][m_n-dd[c]] : 1'b0) ^ f[c];
    end
    b_enable = en; b_valid = v; b_clear = clr; b_ref = r; b_rx = x;
    if (clr)
      for (int c = 0; c < 2; c++) begin m_err[c] = 0; m_bits[c] = 0; end
    if (en && v) begin
      for (int c = 0; c < 2; c++) begin
        mm = int'(x[c] ^ ((m_n >= m_dly[c]) ? hb[c][m_n-m_dly[c]] : 1'b0));
        if (m_lk[c] != 0 && !clr) begin
          m_bits[c] = (m_bits[c] >= BMAX) ? BMAX : m_bits[c] + 1;
          m_err[c] = (m_err[c] + mm > BMAX) ? BMAX : m_err[c] + mm;
        end
        m_ew[c] += mm;
        if (m_w == BW - 1) begin
          if (m_lk[c] == 0) begin
            if (m_ew[c] <= BLT) m_lk[c] = 1;
            else m_dly[c] = (m_dly[c] + 1) % BD;
          end else if (m_ew[c] > BUT) begin
            m_lk[c] = 0;
            m_dly[c] = (m_dly[c] + 1) % BD;
          end
          m_ew[c] = 0;
        end
      end
      m_w = (m_w + 1) % BW;
      m_n++;
    end
    step();
  endtask

  task automatic b_check();
    chk("b_all_locked", b_all, (m_lk[0] != 0 && m_lk[1] != 0));
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("b_lock%0d", c), b_lock[c], m_lk[c] != 0);
      chk($sformatf("b_delay%0d", c), b_delay[c*BNB +: BNB], m_dly[c]);
      chk($sformatf("b_err%0d", c), b_err[c*BCNT +: BCNT], m_err[c]);
      chk($sformatf("b_bits%0d", c), b_bits[c*BCNT +: BCNT], m_bits[c]);
    end
  endtask

  task automatic b_do_reset();
    b_reset = 1'b0;
    repeat (2) begin
      b_enable = 1'($urandom); b_valid = 1'($urandom); b_clear = 1'($urandom);
      b_ref = 2'($urandom); b_rx = 2'($urandom);
      step();
    end
    m_reset();
    b_reset = 1'b1; b_enable = 1'b1; b_valid = 1'b0; b_clear = 1'b0;
  endtask

  typedef struct {
    int d0, d1, n;
    logic [1:0] lock;
    int dly0, dly1, bits0;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int rs[4];
    int rden, d0, d1, exp_b1;
    logic rb;
    logic [1:0] f;
    tbl = '{'{0, 0, 31,  2'b00, 0, 0, 0},
            '{0, 0, 32,  2'b11, 0, 0, 0},
            '{0, 1, 40,  2'b01, 0, 1, 8},
            '{2, 1, 64,  2'b10, 2, 1, 0},
            '{3, 7, 140, 2'b01, 3, 4, 12},
            '{7, 5, 276, 2'b11, 7, 5, 15},
            '{1, 0, 63,  2'b10, 1, 0, 0}};
    rs = '{0, 32, 8, 2};
    a_reset = 1'b0; a_enable = 1'b0; a_valid = 1'b0; a_clear = 1'b0; a_ref = '0; a_rx = '0;
    b_reset = 1'b0; b_enable = 1'b0; b_valid = 1'b0; b_clear = 1'b0; b_ref = '0; b_rx = '0;
    repeat (5) begin
      a_enable = 1'($urandom); a_valid = 1'($urandom); a_clear = 1'($urandom);
      a_ref = 2'($urandom); a_rx = 2'($urandom);
      step();
    end
    chk("a_rst_lock", a_lock, 0);
    chk("a_rst_all", a_all, 0);
    chk("a_rst_delay", a_delay, 0);
    chk("a_rst_err", a_err, 0);
    chk("a_rst_bits", a_bits, 0);
    a_reset = 1'b1; a_enable = 1'b1; a_valid = 1'b0; a_clear = 1'b0;
    repeat (63) a_strobe(0, 0, 3);
    chk("a_lock_first_win", a_lock, 0);
    repeat (2431 - 63) a_strobe(0, 0, 3);
    chk("a_lock_before", a_lock, 0);
    a_strobe(0, 0, 3);
    chk("a_lock_acq", a_lock, 2'b11);
    chk("a_all_acq", a_all, 1);
    chk("a_delay_acq", a_delay, {9'd37, 9'd37});
    chk("a_err_acq", a_err, 0);
    chk("a_bits_acq", a_bits, 0);
    repeat (AW) a_strobe(0, 0, 0);
    chk("a_bits_win", a_bits, {64'd64, 64'd64});
    chk("a_err_win", a_err, 0);
    for (int i = 0; i < 4 * AW; i++) a_strobe(i % 16 == 0, 0, 0);
    chk("a_tol_err0", a_err[63:0], 16);
    chk("a_tol_err1", a_err[127:64], 0);
    chk("a_tol_bits0", a_bits[63:0], 320);
    chk("a_tol_lock", a_lock, 2'b11);
    a_clear = 1'b1;
    a_strobe(1, 0, 0);
    a_clear = 1'b0;
    chk("a_clr_err", a_err, 0);
    chk("a_clr_bits", a_bits, 0);
    chk("a_clr_lock", a_lock, 2'b11);
    a_strobe(0, 0, 0);
    chk("a_clr_next_bits0", a_bits[63:0], 1);
    while (a_n % AW != 0) a_strobe(0, 0, 0);
    repeat (AW - 1) a_strobe(0, 1, 0);
    chk("a_unlock_hold", a_lock, 2'b11);
    a_strobe(0, 1, 0);
    exp_b1 = since_clr;
    chk("a_unlock_lock", a_lock, 2'b01);
    chk("a_unlock_delay1", a_delay[17:9], 38);
    chk("a_unlock_err1", a_err[127:64], 64);
    chk("a_unlock_bits1", a_bits[127:64], exp_b1);
    repeat (AW) a_strobe(0, 1, 0);
    chk("a_frz_err1", a_err[127:64], 64);
    chk("a_frz_bits1", a_bits[127:64], exp_b1);
    chk("a_frz_delay1", a_delay[17:9], 39);
    chk("a_frz_bits0", a_bits[63:0], since_clr);
    repeat (473 * AW) a_strobe(0, 0, 0);
    chk("a_wrap_delay1", a_delay[17:9], 0);
    chk("a_wrap_lock", a_lock, 2'b01);
    repeat (37 * AW) a_strobe(0, 0, 0);
    chk("a_search_delay1", a_delay[17:9], 37);
    chk("a_search_lock", a_lock, 2'b01);
    repeat (AW) a_strobe(0, 0, 0);
    chk("a_relock_lock", a_lock, 2'b11);
    chk("a_relock_all", a_all, 1);
    chk("a_relock_delay1", a_delay[17:9], 37);
    chk("a_relock_err1", a_err[127:64], 64);
    chk("a_relock_bits1", a_bits[127:64], exp_b1);

    for (int i = 0; i < 7; i++) begin
      b_do_reset();
      for (int j = 0; j < tbl[i].n; j++) begin
        rb = prbs();
        b_cycle(1, 1, 0, {rb, rb}, 2'b00, tbl[i].d0, tbl[i].d1);
      end
      chk($sformatf("tbl%0d_lock", i), b_lock, tbl[i].lock);
      chk($sformatf("tbl%0d_delay0", i), b_delay[2:0], tbl[i].dly0);
      chk($sformatf("tbl%0d_delay1", i), b_delay[5:3], tbl[i].dly1);
      chk($sformatf("tbl%0d_bits0", i), b_bits[3:0], tbl[i].bits0);
      chk($sformatf("tbl%0d_err", i), b_err, 0);
    end

    b_do_reset();
    repeat (BW) begin rb = prbs(); b_cycle(1, 1, 0, {rb, rb}, 2'b00, 0, 0); end
    chk("sat_lock", b_lock, 2'b11);
    repeat (20) begin rb = prbs(); b_cycle(1, 1, 0, {rb, rb}, 2'b00, 0, 0); end
    chk("sat_bits", b_bits, 8'hff);
    repeat (10) begin rb = prbs(); b_cycle(0, 1, 0, {rb, rb}, 2'b11, 0, 0); end
    chk("en_lock", b_lock, 2'b11);
    chk("en_delay", b_delay, 0);
    chk("en_err", b_err, 0);
    chk("en_bits", b_bits, 8'hff);
    b_cycle(0, 0, 1, 2'b00, 2'b00, 0, 0);
    chk("en_clr_bits", b_bits, 0);
    chk("en_clr_lock", b_lock, 2'b11);

    for (int ph = 0; ph < 8; ph++) begin
      b_do_reset();
      b_check();
      d0 = $urandom_range(0, BD - 1);
      d1 = $urandom_range(0, BD - 1);
      rden = rs[$urandom_range(0, 3)];
      for (int cyc = 0; cyc < 2000; cyc++) begin
        for (int c = 0; c < 2; c++)
          f[c] = (rden != 0) && ($urandom_range(0, rden - 1) == 0);
        b_cycle($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 63) == 0, 2'($urandom), f, d0, d1);
        b_check();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
